nx_fifo_thresh: RTL

Parametrised synchronous FIFO, successor to the fixed-depth nx_fifo. It adds:
- arbitrary (non-power-of-two) depth;
- programmable almost-full and almost-empty flags;
- an optional registered-output (prefetch) mode;
- an explicit overflow/underflow policy.

It is used wherever the datapath needs elastic buffering with early back-pressure, e.g. between the compression engine stages and the bus-facing interfaces.

---
 rtl/nx_fifo_pkg.sv | 36 +++
 rtl/nx_fifo_thresh_ctrl.sv | 117 +++++++++++
 rtl/nx_fifo_thresh.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/nx_fifo_pkg.sv
// nx_fifo_pkg
//   Shared definitions for the nx_fifo family.
//   - nx_clog2: ceil(log2(value)) for sizing pointers and slot counts.
//   - nx_fifo_status_t: registered status bundle (empty/full/afull/aempty/
//     overflow/underflow), also intended for the multi-channel FIFO.
//   - NX_FIFO_STATUS_RST: value the status bundle takes in reset.
package nx_fifo_pkg;

  function automatic int nx_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic afull;
    logic aempty;
    logic overflow;
    logic underflow;
  } nx_fifo_status_t;

  localparam nx_fifo_status_t NX_FIFO_STATUS_RST = '{
    empty:     1'b1,
    full:      1'b0,
    afull:     1'b0,
    aempty:    1'b1,
    overflow:  1'b0,
    underflow: 1'b0
  };

endpackage

// File: rtl/nx_fifo_thresh_ctrl.sv
// nx_fifo_thresh_ctrl
//   Bookkeeping for nx_fifo_thresh: read/write pointers with wrap at
//   DEPTH-1, occupancy count, registered status flags and error pulses.
//   Ports:
//     clk, rst                 clock, async active-high reset
//     wen, ren, clear          raw requests from the FIFO user
//     oreg_valid               output register currently holds the head
//     oreg_valid_nxt           output register valid for the next cycle
//     pf_load                  head of the array moves to the output register
//     rptr, wptr               array read/write pointers
//     wr_accept, rd_accept     this cycle's write/read are performed
//     arr_nonempty             the array (excluding output register) has data
//     used_slots, free_slots   registered occupancy counts
//     status                   registered status bundle
module nx_fifo_thresh_ctrl
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int OUT_REG       = 0,
  parameter int CW            = nx_clog2(DEPTH + 1),
  parameter int PW            = nx_clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic            ren,
  input  logic            clear,
  input  logic            oreg_valid,
  input  logic            oreg_valid_nxt,
  input  logic            pf_load,
  output logic [PW-1:0]   rptr,
  output logic [PW-1:0]   wptr,
  output logic            wr_accept,
  output logic            rd_accept,
  output logic            arr_nonempty,
  output logic [CW-1:0]   used_slots,
  output logic [CW-1:0]   free_slots,
  output nx_fifo_status_t status
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   free_q, free_d;
  nx_fifo_status_t st_q, st_d;
  logic            arr_pop;

  // Explicit compare-and-reset wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_accept = !clear && ren && !st_q.empty;
    wr_accept = !clear && wen && (!st_q.full || rd_accept);

    // The count includes the output register, so the array alone is
    // non-empty when the count exceeds the output register's share.
    arr_nonempty = (cnt_q != CW'(oreg_valid));

    // With the output register, the array is drained by the prefetch;
    // without it, directly by the accepted read.
    arr_pop = (OUT_REG != 0) ? pf_load : rd_accept;

    cnt_d  = cnt_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (clear) begin
      cnt_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(wr_accept) - CW'(rd_accept);
      if (arr_pop)   rptr_d = ptr_inc(rptr_q);
      if (wr_accept) wptr_d = ptr_inc(wptr_q);
    end
    free_d = DEPTH_C - cnt_d;

    st_d           = NX_FIFO_STATUS_RST;
    st_d.empty     = (OUT_REG != 0) ? !oreg_valid_nxt : (cnt_d == '0);
    st_d.full      = (cnt_d == DEPTH_C);
    st_d.afull     = (cnt_d >= AFULL_C);
    st_d.aempty    = (cnt_d <= AEMPTY_C);
    st_d.overflow  = !clear && wen && !wr_accept;
    st_d.underflow = !clear && ren && st_q.empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      free_q <= DEPTH_C;
      st_q   <= NX_FIFO_STATUS_RST;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      free_q <= free_d;
      st_q   <= st_d;
    end
  end

  assign rptr       = rptr_q;
  assign wptr       = wptr_q;
  assign used_slots = cnt_q;
  assign free_slots = free_q;
  assign status     = st_q;

endmodule

// File: rtl/nx_fifo_thresh.sv
// nx_fifo_thresh
//   Synchronous FIFO with arbitrary depth, programmable almost-full /
//   almost-empty flags, optional prefetch output register and registered
//   overflow/underflow pulses.
//   Ports:
//     clk, rst        clock, async active-high reset
//     wen, ren        write / read requests
//     clear           synchronous flush (wins over wen/ren)
//     wdata           write data
//     rdata           head-of-queue data, 0 when empty
//     empty, full     no readable data / used_slots == DEPTH
//     afull, aempty   used_slots >= AFULL_THRESH / <= AEMPTY_THRESH
//     used_slots      occupied entries (array plus output register)
//     free_slots      DEPTH - used_slots
//     overflow        1-cycle pulse after a rejected write
//     underflow       1-cycle pulse after a rejected read
module nx_fifo_thresh
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int WIDTH         = 128,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int OUT_REG       = 0,
  parameter int DATA_RESET    = 1,
  parameter int CW            = nx_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic             ren,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             aempty,
  output logic [CW-1:0]    used_slots,
  output logic [CW-1:0]    free_slots,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = nx_clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovalid_q, ovalid_d;
  logic             pf_load;
  logic [PW-1:0]    rptr, wptr;
  logic             wr_accept, rd_accept, arr_nonempty;
  nx_fifo_status_t  status;

  nx_fifo_thresh_ctrl #(
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH),
    .OUT_REG       (OUT_REG),
    .CW            (CW),
    .PW            (PW)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .wen            (wen),
    .ren            (ren),
    .clear          (clear),
    .oreg_valid     (ovalid_q),
    .oreg_valid_nxt (ovalid_d),
    .pf_load        (pf_load),
    .rptr           (rptr),
    .wptr           (wptr),
    .wr_accept      (wr_accept),
    .rd_accept      (rd_accept),
    .arr_nonempty   (arr_nonempty),
    .used_slots     (used_slots),
    .free_slots     (free_slots),
    .status         (status)
  );

  // Prefetch: refill the output register whenever it is free or being
  // consumed this cycle. A word written this cycle is not bypassed; it
  // becomes prefetchable on the following edge.
  always_comb begin
    pf_load  = 1'b0;
    ovalid_d = 1'b0;
    if (OUT_REG != 0) begin
      pf_load = !clear && arr_nonempty && (!ovalid_q || rd_accept);
      if (clear)          ovalid_d = 1'b0;
      else if (pf_load)   ovalid_d = 1'b1;
      else if (rd_accept) ovalid_d = 1'b0;
      else                ovalid_d = ovalid_q;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_accept) mem_d[wptr] = wdata;
    dout_d = pf_load ? mem_q[rptr] : dout_q;
  end

  always_comb begin
    if (status.empty)      rdata = '0;
    else if (OUT_REG != 0) rdata = dout_q;
    else                   rdata = mem_q[rptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovalid_q <= 1'b0;
    else     ovalid_q <= ovalid_d;
  end

  generate
    if (DATA_RESET != 0) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
          dout_q <= '0;
        end else begin
          mem_q  <= mem_d;
          dout_q <= dout_d;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        dout_q <= dout_d;
      end
    end
  endgenerate

  assign empty     = status.empty;
  assign full      = status.full;
  assign afull     = status.afull;
  assign aempty    = status.aempty;
  assign overflow  = status.overflow;
  assign underflow = status.underflow;

endmodule
